// File: rtl/rob_pkg.sv
// Shared types and default sizing for the multi-port reorder buffer.
// Holds the entry record and the index-width derivation used by every ROB file.
package rob_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_NUM_WB = 4;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_PHY_W  = 8;
    localparam int ROB_LOG_W  = 5;

    function automatic int rob_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int ROB_IDX_W = rob_idx_w(ROB_DEPTH);

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  reg_write;
        logic [ROB_LOG_W-1:0]  rd_log;
        logic [ROB_PHY_W-1:0]  old_phy;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_wb_select.sv
// Per-entry writeback match: picks the lowest-numbered channel that targets this entry.
module rob_wb_select
    import rob_pkg::*;
#(
    parameter int NUM_WB    = ROB_NUM_WB,
    parameter int IDX_W     = ROB_IDX_W,
    parameter int DATA_W    = ROB_DATA_W,
    parameter int ENTRY_IDX = 0
) (
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_idx,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(ENTRY_IDX);

    // Scanning from the top channel down lets the lowest matching channel overwrite last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_idx[k*IDX_W +: IDX_W] == MY_IDX)) begin
                hit  = 1'b1;
                data = wb_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Circular reorder buffer with NUM_WB writeback ports, in-order single retire
// and mispredict squash of every entry younger than the resolved branch.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int  DEPTH  = ROB_DEPTH,
    parameter int  NUM_WB = ROB_NUM_WB,
    parameter int  DATA_W = ROB_DATA_W,
    parameter int  PHY_W  = ROB_PHY_W,
    localparam int IDX_W  = rob_idx_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [ROB_LOG_W-1:0]     alloc_rd_log,
    input  logic [PHY_W-1:0]         alloc_old_phy,
    input  logic                     alloc_reg_write,
    output logic [IDX_W-1:0]         alloc_idx,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_idx,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic                     br_valid,
    input  logic [IDX_W-1:0]         br_idx,
    input  logic                     br_mispredict,
    output logic                     commit_valid,
    output logic [ROB_LOG_W-1:0]     commit_rd_log,
    output logic [DATA_W-1:0]        commit_data,
    output logic                     commit_reg_write,
    output logic [PHY_W-1:0]         commit_free_phy,
    output logic                     flush,
    output logic [IDX_W:0]           count
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    rob_entry_t           ent_q [DEPTH];
    rob_entry_t           ent_d [DEPTH];
    logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]       count_q, count_d;
    logic                 commit_valid_q, commit_valid_d;
    logic [ROB_LOG_W-1:0] commit_rd_log_q, commit_rd_log_d;
    logic [DATA_W-1:0]    commit_data_q, commit_data_d;
    logic                 commit_reg_write_q, commit_reg_write_d;
    logic [PHY_W-1:0]     commit_free_phy_q, commit_free_phy_d;
    logic                 flush_q, flush_d;

    logic [DEPTH-1:0]     wb_hit;
    logic [DEPTH-1:0]     squash;
    logic [DATA_W-1:0]    wb_sel_data [DEPTH];
    logic                 br_kill, mispredict, do_alloc, do_commit;
    logic [IDX_W-1:0]     age_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        rob_wb_select #(
            .NUM_WB    (NUM_WB),
            .IDX_W     (IDX_W),
            .DATA_W    (DATA_W),
            .ENTRY_IDX (i)
        ) u_sel (
            .wb_valid (wb_valid),
            .wb_idx   (wb_idx),
            .wb_data  (wb_data),
            .hit      (wb_hit[i]),
            .data     (wb_sel_data[i])
        );
    end

    assign br_kill     = br_valid && br_mispredict;
    assign alloc_ready = (count_q < DEPTH_C) && !br_kill;
    assign alloc_idx   = tail_q;
    assign mispredict  = br_kill && ent_q[br_idx].valid;
    assign age_b       = br_idx - head_q;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_commit   = ent_q[head_q].valid && ent_q[head_q].done;

    // Age is distance from head, so "younger than b" is simply a larger age.
    always_comb begin
        logic [IDX_W-1:0] age_i;
        age_i  = '0;
        squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_i     = IDX_W'(i) - head_q;
            squash[i] = mispredict && (age_i > age_b);
        end
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && wb_hit[i] && !squash[i]) begin
                ent_d[i].done = 1'b1;
                ent_d[i].data = wb_sel_data[i];
            end
            if (squash[i]) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
        end

        if (do_commit) begin
            ent_d[head_q].valid = 1'b0;
            ent_d[head_q].done  = 1'b0;
            head_d              = head_q + 1'b1;
        end

        if (do_alloc) begin
            ent_d[tail_q].valid     = 1'b1;
            ent_d[tail_q].done      = 1'b0;
            ent_d[tail_q].reg_write = alloc_reg_write;
            ent_d[tail_q].rd_log    = alloc_rd_log;
            ent_d[tail_q].old_phy   = alloc_old_phy;
            tail_d                  = tail_q + 1'b1;
        end

        // Allocation is blocked during a mispredict, so only the retire can shrink the survivors.
        if (mispredict) begin
            tail_d  = br_idx + 1'b1;
            count_d = {1'b0, age_b} + (IDX_W+1)'(1) - (IDX_W+1)'(do_commit);
        end else begin
            count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
        end
    end

    always_comb begin
        commit_valid_d     = do_commit;
        commit_rd_log_d    = '0;
        commit_data_d      = '0;
        commit_reg_write_d = 1'b0;
        commit_free_phy_d  = '0;
        flush_d            = mispredict;
        if (do_commit) begin
            commit_rd_log_d    = ent_q[head_q].rd_log;
            commit_data_d      = ent_q[head_q].data;
            commit_reg_write_d = ent_q[head_q].reg_write;
            commit_free_phy_d  = ent_q[head_q].old_phy;
        end
    end

    // Only the valid/done flags are reset; payload is qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            commit_valid_q     <= 1'b0;
            commit_rd_log_q    <= '0;
            commit_data_q      <= '0;
            commit_reg_write_q <= 1'b0;
            commit_free_phy_q  <= '0;
            flush_q            <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
                ent_q[i].done  <= 1'b0;
            end
        end else begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            commit_valid_q     <= commit_valid_d;
            commit_rd_log_q    <= commit_rd_log_d;
            commit_data_q      <= commit_data_d;
            commit_reg_write_q <= commit_reg_write_d;
            commit_free_phy_q  <= commit_free_phy_d;
            flush_q            <= flush_d;
            ent_q              <= ent_d;
        end
    end

    assign commit_valid     = commit_valid_q;
    assign commit_rd_log    = commit_rd_log_q;
    assign commit_data      = commit_data_q;
    assign commit_reg_write = commit_reg_write_q;
    assign commit_free_phy  = commit_free_phy_q;
    assign flush            = flush_q;
    assign count            = count_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: a vector table for in-order commit plus
// hand-written sequences for full, multi-port, squash and wrap/reset cases.
module tb_rob_multiport;

    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int NUM_WB = 4;
    localparam int PHY_W  = 8;

    typedef struct {
        logic        alloc_v;
        logic [4:0]  rd;
        logic [7:0]  phy;
        logic        wb_en;
        int          wb_ch;
        logic [3:0]  wb_i;
        logic [31:0] wb_d;
        logic        exp_ready;
        logic [3:0]  exp_idx;
        logic        exp_cv;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic [7:0]  exp_phy;
        logic [4:0]  exp_count;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [4:0]               alloc_rd_log;
    logic [PHY_W-1:0]         alloc_old_phy;
    logic                     alloc_reg_write;
    logic [IDX_W-1:0]         alloc_idx;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*IDX_W-1:0]  wb_idx;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic                     br_valid;
    logic [IDX_W-1:0]         br_idx;
    logic                     br_mispredict;
    logic                     commit_valid;
    logic [4:0]               commit_rd_log;
    logic [DATA_W-1:0]        commit_data;
    logic                     commit_reg_write;
    logic [PHY_W-1:0]         commit_free_phy;
    logic                     flush;
    logic [IDX_W:0]           count;

    vec_t vecs [9];
    int   assert_count = 0;
    int   fail_count   = 0;

    rob_multiport dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_rd_log     (alloc_rd_log),
        .alloc_old_phy    (alloc_old_phy),
        .alloc_reg_write  (alloc_reg_write),
        .alloc_idx        (alloc_idx),
        .wb_valid         (wb_valid),
        .wb_idx           (wb_idx),
        .wb_data          (wb_data),
        .br_valid         (br_valid),
        .br_idx           (br_idx),
        .br_mispredict    (br_mispredict),
        .commit_valid     (commit_valid),
        .commit_rd_log    (commit_rd_log),
        .commit_data      (commit_data),
        .commit_reg_write (commit_reg_write),
        .commit_free_phy  (commit_free_phy),
        .flush            (flush),
        .count            (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        alloc_valid     = 1'b0;
        alloc_rd_log    = '0;
        alloc_old_phy   = '0;
        alloc_reg_write = 1'b0;
        wb_valid        = '0;
        wb_idx          = '0;
        wb_data         = '0;
        br_valid        = 1'b0;
        br_idx          = '0;
        br_mispredict   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setWb(input int ch, input logic [3:0] idx, input logic [31:0] data);
        wb_valid[ch]              = 1'b1;
        wb_idx[ch*IDX_W +: IDX_W] = idx;
        wb_data[ch*DATA_W +: DATA_W] = data;
    endtask

    task automatic allocOne(input logic [4:0] rd, input logic [7:0] phy, input logic rw);
        alloc_valid     = 1'b1;
        alloc_rd_log    = rd;
        alloc_old_phy   = phy;
        alloc_reg_write = rw;
        tick();
        alloc_valid     = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idleInputs();
        alloc_valid     = v.alloc_v;
        alloc_rd_log    = v.rd;
        alloc_old_phy   = v.phy;
        alloc_reg_write = v.alloc_v;
        if (v.wb_en) setWb(v.wb_ch, v.wb_i, v.wb_d);
    endtask

    initial begin
        int seen;

        vecs[0] = '{1'b1, 5'd5, 8'h25, 1'b0, 0, 4'd0, 32'h0,    1'b1, 4'd0, 1'b0, 5'd0, 32'h0,    8'h00, 5'd1};
        vecs[1] = '{1'b1, 5'd6, 8'h26, 1'b0, 0, 4'd0, 32'h0,    1'b1, 4'd1, 1'b0, 5'd0, 32'h0,    8'h00, 5'd2};
        vecs[2] = '{1'b1, 5'd7, 8'h27, 1'b0, 0, 4'd0, 32'h0,    1'b1, 4'd2, 1'b0, 5'd0, 32'h0,    8'h00, 5'd3};
        vecs[3] = '{1'b0, 5'd0, 8'h00, 1'b1, 1, 4'd2, 32'h2222, 1'b1, 4'd3, 1'b0, 5'd0, 32'h0,    8'h00, 5'd3};
        vecs[4] = '{1'b0, 5'd0, 8'h00, 1'b1, 2, 4'd0, 32'hA0,   1'b1, 4'd3, 1'b0, 5'd0, 32'h0,    8'h00, 5'd3};
        vecs[5] = '{1'b0, 5'd0, 8'h00, 1'b1, 3, 4'd1, 32'hA1,   1'b1, 4'd3, 1'b1, 5'd5, 32'hA0,   8'h25, 5'd2};
        vecs[6] = '{1'b0, 5'd0, 8'h00, 1'b0, 0, 4'd0, 32'h0,    1'b1, 4'd3, 1'b1, 5'd6, 32'hA1,   8'h26, 5'd1};
        vecs[7] = '{1'b0, 5'd0, 8'h00, 1'b0, 0, 4'd0, 32'h0,    1'b1, 4'd3, 1'b1, 5'd7, 32'h2222, 8'h27, 5'd0};
        vecs[8] = '{1'b0, 5'd0, 8'h00, 1'b0, 0, 4'd0, 32'h0,    1'b1, 4'd3, 1'b0, 5'd0, 32'h0,    8'h00, 5'd0};

        rst = 1'b1;
        idleInputs();
        #2;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_commit_valid", commit_valid, 0);
        checkOutput("reset_flush", flush, 0);
        checkOutput("reset_alloc_idx", alloc_idx, 0);
        doReset();

        // In-order retirement from out-of-order writebacks
        $display("[TB] in-order commit table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_alloc_ready", i), alloc_ready, vecs[i].exp_ready);
            if (vecs[i].alloc_v) checkOutput($sformatf("vec%0d_alloc_idx", i), alloc_idx, vecs[i].exp_idx);
            tick();
            checkOutput($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            checkOutput($sformatf("vec%0d_commit_valid", i), commit_valid, vecs[i].exp_cv);
            if (vecs[i].exp_cv) begin
                checkOutput($sformatf("vec%0d_commit_rd", i), commit_rd_log, vecs[i].exp_rd);
                checkOutput($sformatf("vec%0d_commit_data", i), commit_data, vecs[i].exp_data);
                checkOutput($sformatf("vec%0d_commit_phy", i), commit_free_phy, vecs[i].exp_phy);
                checkOutput($sformatf("vec%0d_commit_rw", i), commit_reg_write, 1);
            end
        end
        idleInputs();

        // Full buffer, then retire with allocation held
        $display("[TB] full buffer");
        doReset();
        for (int i = 0; i < 16; i++) begin
            alloc_valid     = 1'b1;
            alloc_rd_log    = 5'(i);
            alloc_old_phy   = 8'(i);
            alloc_reg_write = 1'b1;
            #1;
            checkOutput($sformatf("fill%0d_ready", i), alloc_ready, 1);
            checkOutput($sformatf("fill%0d_idx", i), alloc_idx, i);
            tick();
        end
        checkOutput("full_count", count, 16);
        checkOutput("full_ready", alloc_ready, 0);
        setWb(0, 4'd0, 32'hF0);
        #1;
        checkOutput("full_wb_ready", alloc_ready, 0);
        tick();
        wb_valid = '0;
        #1;
        checkOutput("full_retire_cycle_ready", alloc_ready, 0);
        tick();
        checkOutput("full_retire_cv", commit_valid, 1);
        checkOutput("full_retire_data", commit_data, 32'hF0);
        checkOutput("full_retire_count", count, 15);
        checkOutput("full_after_ready", alloc_ready, 1);
        checkOutput("full_after_idx", alloc_idx, 0);
        tick();
        checkOutput("full_refill_count", count, 16);
        idleInputs();

        // Two entries completed in the same cycle on channels 0 and 3
        $display("[TB] dual completion");
        doReset();
        allocOne(5'd10, 8'h30, 1'b1);
        allocOne(5'd11, 8'h31, 1'b0);
        setWb(0, 4'd0, 32'hC0);
        setWb(3, 4'd1, 32'hC1);
        tick();
        idleInputs();
        checkOutput("dual_wb_cv", commit_valid, 0);
        tick();
        checkOutput("dual_c0_cv", commit_valid, 1);
        checkOutput("dual_c0_rd", commit_rd_log, 10);
        checkOutput("dual_c0_data", commit_data, 32'hC0);
        checkOutput("dual_c0_rw", commit_reg_write, 1);
        checkOutput("dual_c0_phy", commit_free_phy, 8'h30);
        tick();
        checkOutput("dual_c1_cv", commit_valid, 1);
        checkOutput("dual_c1_rd", commit_rd_log, 11);
        checkOutput("dual_c1_data", commit_data, 32'hC1);
        checkOutput("dual_c1_rw", commit_reg_write, 0);
        tick();
        checkOutput("dual_done_cv", commit_valid, 0);
        checkOutput("dual_done_count", count, 0);

        // Same index on channels 1 and 2: lower channel wins
        $display("[TB] same-index writeback");
        doReset();
        for (int i = 0; i < 5; i++) allocOne(5'(i + 1), 8'(8'h40 + i), 1'b1);
        for (int k = 0; k < 4; k++) setWb(k, 4'(k), 32'(32'hD0 + k));
        tick();
        idleInputs();
        setWb(1, 4'd4, 32'hAAAA);
        setWb(2, 4'd4, 32'hBBBB);
        tick();
        idleInputs();
        checkOutput("same_c0_data", commit_data, 32'hD0);
        for (int k = 1; k < 4; k++) begin
            tick();
            checkOutput($sformatf("same_c%0d_data", k), commit_data, 32'hD0 + k);
        end
        tick();
        checkOutput("same_idx_cv", commit_valid, 1);
        checkOutput("same_idx_lowest_wins", commit_data, 32'hAAAA);
        checkOutput("same_idx_count", count, 0);

        // Mispredict squash with a same-cycle writeback to a squashed entry
        $display("[TB] mispredict squash");
        doReset();
        for (int i = 0; i < 6; i++) allocOne(5'(20 + i), 8'(8'h50 + i), 1'b1);
        checkOutput("sq_pre_count", count, 6);
        br_valid = 1'b1; br_idx = 4'd2; br_mispredict = 1'b0;
        #1;
        checkOutput("sq_predict_ok_ready", alloc_ready, 1);
        tick();
        checkOutput("sq_predict_ok_flush", flush, 0);
        checkOutput("sq_predict_ok_count", count, 6);
        br_mispredict = 1'b1;
        alloc_valid = 1'b1; alloc_rd_log = 5'd31;
        setWb(0, 4'd4, 32'h4444);
        #1;
        checkOutput("sq_ready_blocked", alloc_ready, 0);
        tick();
        idleInputs();
        checkOutput("sq_flush_pulse", flush, 1);
        checkOutput("sq_count", count, 3);
        checkOutput("sq_tail", alloc_idx, 3);
        tick();
        checkOutput("sq_flush_drop", flush, 0);
        br_valid = 1'b1; br_idx = 4'd9; br_mispredict = 1'b1;
        tick();
        idleInputs();
        checkOutput("sq_invalid_br_flush", flush, 0);
        checkOutput("sq_invalid_br_count", count, 3);
        setWb(0, 4'd0, 32'hE0);
        setWb(1, 4'd1, 32'hE1);
        setWb(2, 4'd2, 32'hE2);
        setWb(3, 4'd4, 32'hE4);
        tick();
        idleInputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("sq_c%0d_cv", k), commit_valid, 1);
            checkOutput($sformatf("sq_c%0d_rd", k), commit_rd_log, 20 + k);
            checkOutput($sformatf("sq_c%0d_data", k), commit_data, 32'hE0 + k);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (commit_valid) seen++;
        end
        checkOutput("sq_squashed_never_commits", seen, 0);
        checkOutput("sq_final_count", count, 0);

        // Wrap-around streaming, then asynchronous reset mid-stream
        $display("[TB] wrap-around stream");
        doReset();
        for (int n = 0; n < 40; n++) begin
            idleInputs();
            alloc_valid     = 1'b1;
            alloc_rd_log    = 5'(n % 32);
            alloc_old_phy   = 8'(n);
            alloc_reg_write = 1'b1;
            if (n >= 1) setWb(0, 4'((n - 1) % 16), 32'(32'h1000 + n - 1));
            #1;
            checkOutput($sformatf("wrap%0d_ready", n), alloc_ready, 1);
            checkOutput($sformatf("wrap%0d_idx", n), alloc_idx, n % 16);
            tick();
            if (n >= 2) begin
                checkOutput($sformatf("wrap%0d_cv", n), commit_valid, 1);
                checkOutput($sformatf("wrap%0d_rd", n), commit_rd_log, (n - 2) % 32);
                checkOutput($sformatf("wrap%0d_data", n), commit_data, 32'h1000 + n - 2);
                checkOutput($sformatf("wrap%0d_phy", n), commit_free_phy, n - 2);
                checkOutput($sformatf("wrap%0d_count", n), count, 2);
            end else begin
                checkOutput($sformatf("wrap%0d_count", n), count, n + 1);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_cv", commit_valid, 0);
        checkOutput("rst_mid_rd", commit_rd_log, 0);
        checkOutput("rst_mid_data", commit_data, 0);
        checkOutput("rst_mid_rw", commit_reg_write, 0);
        checkOutput("rst_mid_phy", commit_free_phy, 0);
        checkOutput("rst_mid_flush", flush, 0);
        checkOutput("rst_mid_count", count, 0);
        checkOutput("rst_mid_alloc_idx", alloc_idx, 0);
        idleInputs();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_cv", commit_valid, 0);
        checkOutput("post_rst_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/rob_multiport.md
ROB_MULTIPORT -- requirements
Module: rob_multiport

Interface
REQ-001 Parameters: DEPTH, default 16, entry count, power of 2, at least 4; NUM_WB, default 4, writeback channels; DATA_W, default 32, result width; PHY_W, default 8, physical tag width; IDX_W = log2(DEPTH).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 alloc_valid  in  1  dispatch requests a new entry.
REQ-005 alloc_ready  out  1  entry can be accepted this cycle (combinational).
REQ-006 alloc_rd_log  in  5  logical destination register.
REQ-007 alloc_old_phy  in  PHY_W  previous physical mapping of rd, freed at commit.
REQ-008 alloc_reg_write  in  1  instruction writes rd.
REQ-009 alloc_idx  out  IDX_W  index of the entry granted, equal to the tail pointer.
REQ-010 wb_valid  in  NUM_WB  per-channel writeback strobe.
REQ-011 wb_idx  in  NUM_WB*IDX_W  per-channel target entry, channel k in bits [k*IDX_W +: IDX_W].
REQ-012 wb_data  in  NUM_WB*DATA_W  per-channel result, packed the same way as wb_idx.
REQ-013 br_valid  in  1  branch resolved this cycle.
REQ-014 br_idx  in  IDX_W  entry index of the resolved branch.
REQ-015 br_mispredict  in  1  the resolved branch was mispredicted.
REQ-016 commit_valid  out  1  one-cycle retire pulse.
REQ-017 commit_rd_log  out  5  retired destination register.
REQ-018 commit_data  out  DATA_W  retired result.
REQ-019 commit_reg_write  out  1  the retired entry writes the architectural register.
REQ-020 commit_free_phy  out  PHY_W  tag returned to the free list.
REQ-021 flush  out  1  one-cycle pulse after a mispredict squash.
REQ-022 count  out  IDX_W+1  number of occupied entries.

Function
REQ-023 The buffer SHALL be circular, using head and tail pointers modulo DEPTH plus a count register.
REQ-024 alloc_ready SHALL be (count < DEPTH) AND NOT (br_valid AND br_mispredict); it SHALL NOT depend on a commit in the same cycle.
REQ-025 An allocation SHALL occur when alloc_valid AND alloc_ready. The entry becomes valid and not done, and tail increments.
REQ-026 For each channel k with wb_valid[k] and a valid target entry, the entry SHALL set done and capture wb_data. Writebacks to invalid entries SHALL be ignored.
REQ-027 Several channels SHALL be able to complete distinct entries in the same cycle. If two channels target the same index, the lowest channel number wins.
REQ-028 On a rising edge where the head entry is valid and done, the buffer SHALL retire it: invalidate the entry, increment head, and register the commit_* outputs with commit_valid=1 for exactly one cycle. At most one entry retires per cycle.
REQ-029 A writeback to the head entry at edge t SHALL produce commit_valid during the cycle after edge t+1.
REQ-030 br_valid with br_mispredict=0 SHALL have no effect on the buffer state.
REQ-031 br_valid with br_mispredict=1 on a valid entry b SHALL, in that cycle:
  - invalidate every entry strictly younger than b;
  - set tail to b+1 mod DEPTH and recompute count;
  - register flush=1 for the following cycle.
REQ-032 A writeback that targets an entry squashed in the same cycle SHALL be dropped.
REQ-033 If entry b is also retired in the same cycle, retirement and squash SHALL both take effect.
REQ-034 A mispredict on an invalid br_idx SHALL be ignored, and flush SHALL NOT pulse.
REQ-035 Allocate and retire in the same cycle SHALL leave count unchanged.
REQ-036 Pointer wrap-around SHALL be seamless; count distinguishes full from empty.
REQ-037 No retirement SHALL occur when count is 0.

Reset
REQ-038 rst SHALL asynchronously clear head, tail, count, all entry valid and done bits, commit_valid, commit_reg_write, commit_rd_log, commit_data, commit_free_phy and flush to 0, including in the middle of an operation.
REQ-039 Entry payload storage SHALL need no reset.

Structure
REQ-040 The default parameter values, IDX_W derivation and the entry record type (valid, done, reg_write, rd_log, old_phy, data) SHALL live in the shared package rob_pkg.
REQ-041 Per-entry writeback selection (lowest-channel-wins match across NUM_WB channels) SHALL be the sub-module rob_wb_select, instantiated once per entry.

Verification
REQ-042 The bench SHALL allocate 3 entries (rd x5, x6, x7), write back idx 2, then 0, then 1 on different channels, and check that commits appear in order x5, x6, x7, one per cycle, with matching data.
REQ-043 The bench SHALL allocate 16 entries with DEPTH=16 and check alloc_ready=0 and count=16. It SHALL then complete the head with allocate held and check that alloc_ready stays 0 that cycle and rises after the retire.
REQ-044 The bench SHALL complete entries 0 and 1 in the same cycle on channels 0 and 3, and check two commits on consecutive cycles.
REQ-045 The bench SHALL drive channels 1 and 2 to idx 4 in the same cycle with data 0xAAAA and 0xBBBB, and check that commit_data is 0xAAAA.
REQ-046 With 6 entries valid (idx 0-5), the bench SHALL assert a mispredict on idx 2 together with a writeback to idx 4. It SHALL check that flush pulses the next cycle, tail=3 and count=3, and that idx 4 never commits.
REQ-047 The bench SHALL run wrap-around: 40 alloc/commit cycles with DEPTH=16, then assert rst mid-stream, and check that all outputs are 0 immediately and count=0.
